// File: rtl/spi_tx_meas_frame.sv
// Pulse frequency/period meter that snapshots one tagged 16-bit frame
// per SPI capture strobe; the 2-bit SPI command picks the frame content.
//
// Ports:
//   i_clk, i_rst         clock, async active-high reset
//   i_pulse              external pulse (asynchronous, synchronised here)
//   i_data_capt_st       SPI slave capture strobe (rising edge = snapshot)
//   i_rx_cmd[1:0]        last SPI command: 00 freq, 01 period,
//                        10 status, 11 link-test pattern
//   o_tx_word[15:0]      {seq[1:0], ovf, stale, data[11:0]}
//   o_word_valid         set by the first snapshot
module spi_tx_meas_frame #(
  parameter int          TX_BUFF_BITS = 16,
  parameter int          COUNT_BITS   = 12,
  parameter int          GATE_CYCLES  = 50000,
  parameter logic [7:0]  VERSION      = 8'h01
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_pulse,
  input  logic                    i_data_capt_st,
  input  logic [1:0]              i_rx_cmd,
  output logic [TX_BUFF_BITS-1:0] o_tx_word,
  output logic                    o_word_valid
);

  localparam int GW = $clog2(GATE_CYCLES);
  localparam logic [COUNT_BITS-1:0] CMAX = '1;
  localparam logic [GW-1:0] GLAST = GW'(GATE_CYCLES - 1);

  logic                    p_s1_q, p_s2_q, p_s3_q;
  logic                    capt_q;
  logic [GW-1:0]           gate_cnt_q, gate_cnt_d;
  logic [COUNT_BITS-1:0]   pcnt_q, pcnt_d;
  logic                    ovf_w_q, ovf_w_d;
  logic [COUNT_BITS-1:0]   freq_res_q, freq_res_d;
  logic                    freq_ovf_q, freq_ovf_d;
  logic                    new_f_q, new_f_d;
  logic [COUNT_BITS-1:0]   per_cnt_q, per_cnt_d;
  logic [COUNT_BITS-1:0]   per_res_q, per_res_d;
  logic                    per_ovf_q, per_ovf_d;
  logic                    per_armed_q, per_armed_d;
  logic                    new_p_q, new_p_d;
  logic [1:0]              seq_q, seq_d;
  logic [TX_BUFF_BITS-1:0] tx_word_q, tx_word_d;
  logic                    valid_q, valid_d;

  logic                    pedge;
  logic                    gate_end;
  logic                    trig;
  logic                    pcnt_sat;
  logic                    per_sat;
  logic [COUNT_BITS-1:0]   pcnt_nx;
  logic                    ovf_nx;
  logic                    f_ovf, f_stale;
  logic [11:0]             f_data;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      p_s1_q      <= 1'b0;
      p_s2_q      <= 1'b0;
      p_s3_q      <= 1'b0;
      capt_q      <= 1'b0;
      gate_cnt_q  <= '0;
      pcnt_q      <= '0;
      ovf_w_q     <= 1'b0;
      freq_res_q  <= '0;
      freq_ovf_q  <= 1'b0;
      new_f_q     <= 1'b0;
      per_cnt_q   <= '0;
      per_res_q   <= '0;
      per_ovf_q   <= 1'b0;
      per_armed_q <= 1'b0;
      new_p_q     <= 1'b0;
      seq_q       <= '0;
      tx_word_q   <= '0;
      valid_q     <= 1'b0;
    end else begin
      p_s1_q      <= i_pulse;
      p_s2_q      <= p_s1_q;
      p_s3_q      <= p_s2_q;
      capt_q      <= i_data_capt_st;
      gate_cnt_q  <= gate_cnt_d;
      pcnt_q      <= pcnt_d;
      ovf_w_q     <= ovf_w_d;
      freq_res_q  <= freq_res_d;
      freq_ovf_q  <= freq_ovf_d;
      new_f_q     <= new_f_d;
      per_cnt_q   <= per_cnt_d;
      per_res_q   <= per_res_d;
      per_ovf_q   <= per_ovf_d;
      per_armed_q <= per_armed_d;
      new_p_q     <= new_p_d;
      seq_q       <= seq_d;
      tx_word_q   <= tx_word_d;
      valid_q     <= valid_d;
    end
  end

  always_comb begin
    pedge    = p_s2_q & ~p_s3_q;
    gate_end = (gate_cnt_q == GLAST);
    trig     = i_data_capt_st & ~capt_q;
    pcnt_sat = (pcnt_q == CMAX);
    per_sat  = (per_cnt_q == CMAX);

    gate_cnt_d = gate_end ? '0 : gate_cnt_q + 1'b1;

    // Edge arriving in the last gate cycle is folded into this window.
    pcnt_nx = (pedge && !pcnt_sat) ? pcnt_q + 1'b1 : pcnt_q;
    ovf_nx  = ovf_w_q | (pedge & pcnt_sat);

    pcnt_d     = pcnt_nx;
    ovf_w_d    = ovf_nx;
    freq_res_d = freq_res_q;
    freq_ovf_d = freq_ovf_q;
    if (gate_end) begin
      freq_res_d = pcnt_nx;
      freq_ovf_d = ovf_nx;
      pcnt_d     = '0;
      ovf_w_d    = 1'b0;
    end

    per_cnt_d   = per_sat ? per_cnt_q : per_cnt_q + 1'b1;
    per_res_d   = per_res_q;
    per_ovf_d   = per_ovf_q;
    per_armed_d = per_armed_q | pedge;
    if (pedge) begin
      per_cnt_d = '0;
      if (per_armed_q) begin
        per_res_d = per_sat ? CMAX : per_cnt_q + 1'b1;
        per_ovf_d = per_sat;
      end
    end

    seq_d     = seq_q;
    tx_word_d = tx_word_q;
    valid_d   = valid_q;
    new_f_d   = new_f_q;
    new_p_d   = new_p_q;
    f_ovf     = 1'b0;
    f_stale   = 1'b0;
    f_data    = 12'h000;

    if (trig) begin
      seq_d   = seq_q + 2'd1;
      valid_d = 1'b1;
      unique case (i_rx_cmd)
        2'b00: begin
          f_data  = 12'(freq_res_q);
          f_ovf   = freq_ovf_q;
          f_stale = ~new_f_q;
          new_f_d = 1'b0;
        end
        2'b01: begin
          f_data  = 12'(per_res_q);
          f_ovf   = per_ovf_q;
          f_stale = ~new_p_q;
          new_p_d = 1'b0;
        end
        2'b10: begin
          f_data = {freq_ovf_q, per_ovf_q, per_armed_q,
                    p_s2_q, VERSION};
        end
        2'b11: begin
          f_data = 12'hA5A;
        end
      endcase
      tx_word_d = TX_BUFF_BITS'({seq_d, f_ovf, f_stale, f_data});
    end

    // A result landing on a snapshot cycle keeps its flag set.
    if (gate_end) new_f_d = 1'b1;
    if (pedge && per_armed_q) new_p_d = 1'b1;
  end

  assign o_tx_word    = tx_word_q;
  assign o_word_valid = valid_q;

endmodule

// File: tb/tb_spi_tx_meas_frame.sv
// Randomised bench for spi_tx_meas_frame: two instances (12- and 4-bit
// counters) checked against an edge-timestamp reference model.
module tb_spi_tx_meas_frame;

  localparam int G = 100;

  logic        clk = 1'b0;
  logic        i_rst;
  logic        i_pulse;
  logic        i_data_capt_st;
  logic [1:0]  i_rx_cmd;
  logic [15:0] tx12, tx4;
  logic        vld12, vld4;

  int n_chk = 0;
  int n_err = 0;

  int cyc;
  bit lvl_hist [0:65535];
  int edges[$];
  int last_s0, last_s1;
  logic [1:0] seq_m;

  always #5 clk = ~clk;

  spi_tx_meas_frame #(
    .COUNT_BITS(12), .GATE_CYCLES(G)
  ) u_dut (
    .i_clk(clk), .i_rst(i_rst), .i_pulse(i_pulse),
    .i_data_capt_st(i_data_capt_st), .i_rx_cmd(i_rx_cmd),
    .o_tx_word(tx12), .o_word_valid(vld12)
  );

  spi_tx_meas_frame #(
    .COUNT_BITS(4), .GATE_CYCLES(G)
  ) u_dut4 (
    .i_clk(clk), .i_rst(i_rst), .i_pulse(i_pulse),
    .i_data_capt_st(i_data_capt_st), .i_rx_cmd(i_rx_cmd),
    .o_tx_word(tx4), .o_word_valid(vld4)
  );

  // cyc = number of rising edges since reset release
  always @(posedge clk or posedge i_rst) begin
    if (i_rst) cyc <= 0;
    else begin
      lvl_hist[cyc+1] <= i_pulse;
      cyc <= cyc + 1;
    end
  end

  task automatic check(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cyc %0d)",
               tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) step();
  endtask

  // Expected frame for a snapshot triggered at rising edge t.
  function automatic logic [15:0] exp_frame(input int cb, input int t,
      input logic [1:0] cmd, input logic [1:0] sq);
    int m, w, c, fres, n, ea, eb, pres, d;
    bit fovf, fnew, povf, pnew, armed, ovf, stale;
    logic [11:0] data;
    m = (1 << cb) - 1;
    w = ((t - 1) / G) * G;
    c = 0;
    foreach (edges[i])
      if (w > 0 && edges[i] > w - G && edges[i] <= w) c++;
    fres = (c > m) ? m : c;
    fovf = (c > m);
    fnew = (w > 0) && (w >= last_s0);
    n = 0; ea = 0; eb = 0;
    foreach (edges[i])
      if (edges[i] <= t - 1) begin
        n++; ea = eb; eb = edges[i];
      end
    armed = (n >= 1);
    pres = 0; povf = 0; pnew = 0;
    if (n >= 2) begin
      d = eb - ea;
      pres = (d > m) ? m : d;
      povf = (d > m);
      pnew = (eb >= last_s1);
    end
    ovf = 0; stale = 0; data = 12'h000;
    case (cmd)
      2'b00: begin data = 12'(fres); ovf = fovf; stale = !fnew; end
      2'b01: begin data = 12'(pres); ovf = povf; stale = !pnew; end
      2'b10: data = {fovf, povf, armed, lvl_hist[t-2], 8'h01};
      default: data = 12'hA5A;
    endcase
    return {sq, ovf, stale, data};
  endfunction

  task automatic pulse_hi();
    i_pulse = 1'b1;
    edges.push_back(cyc + 3);
  endtask

  task automatic pulse(input int hi, input int lo);
    pulse_hi();
    repeat (hi) step();
    i_pulse = 1'b0;
    repeat (lo) step();
  endtask

  task automatic snap(input logic [1:0] cmd, input int hold);
    int t;
    logic [15:0] e12, e4;
    t = cyc + 1;
    seq_m = seq_m + 2'd1;
    e12 = exp_frame(12, t, cmd, seq_m);
    e4  = exp_frame(4, t, cmd, seq_m);
    if (cmd == 2'b00) last_s0 = t;
    if (cmd == 2'b01) last_s1 = t;
    i_rx_cmd = cmd;
    i_data_capt_st = 1'b1;
    step();
    check("frame12", tx12, e12);
    check("frame4", tx4, e4);
    check("valid", {15'd0, vld12 & vld4}, 16'd1);
    repeat (hold - 1) step();
    i_data_capt_st = 1'b0;
    step();
    check("hold12", tx12, e12);
    check("hold4", tx4, e4);
  endtask

  task automatic do_reset();
    i_pulse = 1'b0;
    i_data_capt_st = 1'b0;
    i_rst = 1'b1;
    edges.delete();
    last_s0 = 0;
    last_s1 = 0;
    seq_m = 2'd0;
    step();
    check("rst_word12", tx12, 16'h0000);
    check("rst_word4", tx4, 16'h0000);
    check("rst_valid", {14'd0, vld12, vld4}, 16'd0);
    step();
    i_rst = 1'b0;
  endtask

  initial begin
    i_rst = 1'b1;
    i_pulse = 1'b0;
    i_data_capt_st = 1'b0;
    i_rx_cmd = 2'b00;
    step();
    do_reset();

    // 7 pulses in window 1, then two freq snapshots
    step();
    repeat (7) pulse(1, 5);
    wait_until(G + 1);
    snap(2'b00, 1);
    check("plan1", tx12, 16'h4007);
    snap(2'b00, 1);
    check("plan2", tx12, 16'h9007);

    // period of 25
    do_reset();
    step();
    repeat (3) pulse(1, 24);
    snap(2'b01, 1);
    check("plan3a", tx12, 16'h4019);
    do_reset();
    step();
    pulse(1, 5);
    snap(2'b01, 1);
    check("plan3b", tx12, 16'h5000);

    // 20 pulses: 4-bit instance saturates, next window is clean
    do_reset();
    step();
    repeat (20) pulse(1, 3);
    wait_until(G + 1);
    snap(2'b00, 1);
    check("plan4a", tx4, 16'h600F);
    wait_until(2 * G + 1);
    snap(2'b00, 1);
    check("plan4b", tx4, 16'h8000);

    // long strobe and seq wrap on link-test frames
    snap(2'b11, 5);
    repeat (4) snap(2'b11, 1);

    // snapshot coinciding with gate end keeps new flag
    repeat (4) pulse(1, 4);
    while ((cyc % G) != G - 1) step();
    snap(2'b00, 1);
    snap(2'b00, 1);

    // status frame with the pulse held high
    pulse_hi();
    repeat (6) step();
    snap(2'b10, 1);
    i_pulse = 1'b0;
    repeat (4) step();
    snap(2'b10, 1);

    // random mix of pulses and snapshots
    for (int i = 0; i < 120; i++) begin
      case ($urandom_range(0, 3))
        0, 1: pulse($urandom_range(1, 3), $urandom_range(1, 30));
        2: snap(2'($urandom_range(0, 3)), $urandom_range(1, 3));
        default: repeat ($urandom_range(1, 60)) step();
      endcase
    end

    // reset mid-window, then a full window after release
    do_reset();
    step();
    repeat (3) pulse(1, 4);
    do_reset();
    step();
    repeat (2) pulse(1, 6);
    wait_until(G + 1);
    check("rst_hold12", tx12, 16'h0000);
    check("rst_hold_v", {15'd0, vld12}, 16'd0);
    snap(2'b00, 1);
    check("plan6", tx12, 16'h4002);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
